// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings and requester ids for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_ACK   = 2'd3;

  localparam logic ARB_GNT_IF = 1'b0;
  localparam logic ARB_GNT_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the CPU fetch port and data port.
// One access in flight at a time; data has priority, bounded by a fetch starvation budget.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STK_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              take_if_s;

  // Fetch wins only when data is idle or data has used up its starvation budget.
  assign take_if_s = if_req & (~dm_req | (streak_q == STK_MAX));

  // Next-state, grant latching, latency countdown and streak bookkeeping.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (if_req | dm_req) begin
          state_d  = ARB_ISSUE;
          mem_en_d = 1'b1;
          if (take_if_s) begin
            gnt_d    = ARB_GNT_IF;
            addr_d   = if_addr;
            we_d     = 1'b0;
            streak_d = '0;
          end else begin
            gnt_d    = ARB_GNT_DM;
            addr_d   = dm_addr;
            we_d     = dm_we;
            wdata_d  = dm_wdata;
            mem_we_d = dm_we;
            if (if_req) begin
              if (streak_q != STK_MAX) begin
                streak_d = streak_q + STK_W'(1);
              end else begin
                streak_d = streak_q;
              end
            end else begin
              streak_d = '0;
            end
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_WAIT;
        cnt_d   = LAT_LOAD;
      end
      ARB_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ARB_ACK;
          cnt_d   = '0;
          if (gnt_q == ARB_GNT_IF) begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end else begin
            dm_ack_d = 1'b1;
            if (!we_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_ACK: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= ARB_GNT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign dm_stall  = dm_req & ~dm_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level schedule model and a reference copy of memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack, if_stall;
  logic              dm_req = 1'b0;
  logic              dm_we = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack, dm_stall;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory device: write at the strobe edge, read data valid MEM_LAT cycles after the strobe.
  logic [31:0] mem  [256];
  logic [31:0] pipe [MEM_LAT];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_data = 32'h0;
  always @(posedge clock) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    pipe[0] <= mem_en ? mem[mem_addr[9:2]] : $urandom;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: access schedule and memory contents.
  logic [31:0] ref_mem [256];
  int          free_at = 0;
  int          exp_en  = -1;
  int          exp_ack = -1;
  int          streak  = 0;
  bit          a_if, a_we;
  logic [31:0] a_addr, a_wd, a_rd;
  logic [31:0] e_if_rd = 32'h0, e_dm_rd = 32'h0, e_maddr = 32'h0;

  // Requester state driven onto the DUT each cycle.
  bit          if_pend = 1'b0, dm_pend = 1'b0, dm_wv = 1'b0;
  logic [31:0] if_a = 32'h0, dm_a = 32'h0, dm_wd = 32'h0;
  bit          rand_mode = 1'b0, hold_mode = 1'b0;
  bit          saw_if = 1'b0, saw_dm = 1'b0;

  task automatic cycle_body();
    bit g_if;
    if (rand_mode) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1; if_a = $urandom;
      end
      if (!dm_pend && $urandom_range(0, 2) != 0) begin
        dm_pend = 1'b1; dm_a = $urandom; dm_wv = 1'($urandom_range(0, 1)); dm_wd = $urandom;
      end
      if (cyc >= exp_en && cyc <= exp_ack) begin
        if (a_if) if_a = $urandom;
        else begin dm_a = $urandom; dm_wd = $urandom; end
      end
    end
    if_req = if_pend; if_addr = if_a;
    dm_req = dm_pend; dm_we = dm_wv; dm_addr = dm_a; dm_wdata = dm_wd;

    if (cyc >= free_at && (if_pend || dm_pend)) begin
      g_if = if_pend && (!dm_pend || streak == STARVE_MAX);
      if (g_if) streak = 0;
      else if (if_pend) streak = (streak + 1 > STARVE_MAX) ? STARVE_MAX : streak + 1;
      else streak = 0;
      a_if   = g_if;
      a_addr = g_if ? if_a : dm_a;
      a_we   = !g_if && dm_wv;
      a_wd   = dm_wd;
      if (a_we) ref_mem[a_addr[9:2]] = a_wd;
      a_rd    = ref_mem[a_addr[9:2]];
      exp_en  = cyc + 1;
      exp_ack = cyc + MEM_LAT + 2;
      free_at = cyc + MEM_LAT + 3;
    end

    #1;
    if (cyc == exp_en) e_maddr = a_addr;
    if (cyc == exp_ack) begin
      if (a_if) e_if_rd = a_rd;
      else if (!a_we) e_dm_rd = a_rd;
    end
    check("if_ack",   32'(if_ack),  32'(cyc == exp_ack && a_if));
    check("dm_ack",   32'(dm_ack),  32'(cyc == exp_ack && !a_if));
    check("mem_en",   32'(mem_en),  32'(cyc == exp_en));
    check("mem_we",   32'(mem_we),  32'(cyc == exp_en && a_we));
    check("busy",     32'(busy),    32'(cyc >= exp_en && cyc <= exp_ack));
    check("mem_addr", mem_addr,     e_maddr);
    if (cyc == exp_en && a_we) check("mem_wdata", mem_wdata, a_wd);
    check("if_rdata", if_rdata,     e_if_rd);
    check("dm_rdata", dm_rdata,     e_dm_rd);
    check("if_stall", 32'(if_stall), 32'(if_pend && !(cyc == exp_ack && a_if)));
    check("dm_stall", 32'(dm_stall), 32'(dm_pend && !(cyc == exp_ack && !a_if)));

    saw_if = (if_ack === 1'b1);
    saw_dm = (dm_ack === 1'b1);
    if (saw_if) begin
      if_a = $urandom;
      if (!hold_mode) if_pend = 1'b0;
    end
    if (saw_dm) begin
      dm_a = $urandom;
      if (!hold_mode) dm_pend = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    cycle_body();
  endtask

  // which: 0 = data ack, 1 = fetch ack, 2 = either
  task automatic wait_ack(input int which, input int limit, output int at, output bit was_if);
    bit got;
    got = 1'b0; at = -1; was_if = 1'b0;
    for (int n = 0; n < limit && !got; n++) begin
      tick();
      if ((which != 0 && saw_if) || (which != 1 && saw_dm)) begin
        got = 1'b1; at = cyc; was_if = saw_if;
      end
    end
    check("ack_within_bound", 32'(got), 32'h1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && (if_pend || dm_pend); n++) tick();
    check("drain", 32'(if_pend || dm_pend), 32'h0);
  endtask

  task automatic check_zero(input string t);
    check({t, "_if_rdata"},  if_rdata,         32'h0);
    check({t, "_dm_rdata"},  dm_rdata,         32'h0);
    check({t, "_if_ack"},    32'(if_ack),      32'h0);
    check({t, "_dm_ack"},    32'(dm_ack),      32'h0);
    check({t, "_mem_en"},    32'(mem_en),      32'h0);
    check({t, "_mem_we"},    32'(mem_we),      32'h0);
    check({t, "_mem_addr"},  mem_addr,         32'h0);
    check({t, "_mem_wdata"}, mem_wdata,        32'h0);
    check({t, "_busy"},      32'(busy),        32'h0);
  endtask

  task automatic pulse_reset();
    #1;
    reset = 1'b0;
    #1;
    check_zero("t5_rst");
    @(posedge clock);
    #1;
    cyc++;
    reset   = 1'b1;
    free_at = cyc;
    exp_en  = -1;
    exp_ack = -1;
    streak  = 0;
    e_if_rd = 32'h0;
    e_dm_rd = 32'h0;
    e_maddr = 32'h0;
    cycle_body();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, t0, r;
    bit was_if;

    for (int i = 0; i < 256; i++) begin
      pre_we   = 1'b1;
      pre_idx  = 8'(i);
      pre_data = (i == 4) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = pre_data;
      @(posedge clock);
      #1;
    end
    pre_we = 1'b0;
    check_zero("reset");

    // 1: load from 0x10 presented in cycle 0
    dm_pend = 1'b1; dm_wv = 1'b0; dm_a = 32'h10; dm_wd = 32'h0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc = 0;
    free_at = 0;
    cycle_body();
    wait_ack(0, 20, at, was_if);
    check("t1_ack_cycle", 32'(at), 32'd4);
    check("t1_rdata", dm_rdata, 32'hDEADBEEF);

    // 2: store then read back
    dm_pend = 1'b1; dm_wv = 1'b1; dm_a = 32'h20; dm_wd = 32'h12345678;
    t0 = cyc + 1;
    wait_ack(0, 20, at, was_if);
    check("t2_store_lat", 32'(at - t0), 32'd4);
    dm_pend = 1'b1; dm_wv = 1'b0; dm_a = 32'h20;
    wait_ack(0, 20, at, was_if);
    check("t2_readback", dm_rdata, 32'h12345678);

    // 3: simultaneous requests, data first
    if_pend = 1'b1; if_a = 32'h40;
    dm_pend = 1'b1; dm_wv = 1'b0; dm_a = 32'h10;
    t0 = cyc + 1;
    wait_ack(0, 20, at, was_if);
    check("t3_dm_ack_cycle", 32'(at - t0), 32'd4);
    wait_ack(1, 20, at, was_if);
    check("t3_if_ack_cycle", 32'(at - t0), 32'd9);
    check("t3_if_rdata", if_rdata, ref_mem[16]);

    // 4: both held continuously, fetch forced every fifth grant
    hold_mode = 1'b1;
    if_pend = 1'b1; if_a = $urandom;
    dm_pend = 1'b1; dm_wv = 1'b0; dm_a = $urandom;
    for (int n = 0; n < 10; n++) begin
      wait_ack(2, 20, at, was_if);
      check("t4_grant_order", 32'(was_if), 32'(n % 5 == 4));
    end
    hold_mode = 1'b0;
    drain();

    // 5: reset during WAIT abandons the fetch; it reruns after release
    if_pend = 1'b1; if_a = 32'h0;
    tick();
    tick();
    tick();
    pulse_reset();
    r = cyc;
    wait_ack(1, 20, at, was_if);
    check("t5_ack_after_release", 32'(at - r), 32'd4);
    check("t5_if_rdata", if_rdata, ref_mem[0]);

    // 6: address change after the grant is ignored
    dm_pend = 1'b1; dm_wv = 1'b0; dm_a = 32'h50;
    tick();
    tick();
    tick();
    dm_a = 32'h60; dm_wd = $urandom;
    wait_ack(0, 20, at, was_if);
    check("t6_rdata", dm_rdata, ref_mem[20]);
    check("t6_mem_addr", mem_addr, 32'h50);

    // random traffic with post-grant input scrambling
    rand_mode = 1'b1;
    repeat (500) tick();
    rand_mode = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
